// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types for the scratchpad bank controller
package spm_pkg;

  // Width reserved for the row index carried through the response pipeline.
  localparam int SPM_ROW_W = 8;

  typedef enum logic [0:0] {
    SPM_INIT = 1'b0,
    SPM_RUN  = 1'b1
  } spm_ctrl_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SPM_ROW_W-1:0] row;
    logic                 is_write;
    logic                 oor;
  } spm_rsp_meta_t;

endpackage

// File: rtl/spm_rsp_pipe.sv
// rtl/spm_rsp_pipe.sv - fixed-depth shift register of response metadata
module spm_rsp_pipe
  import spm_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  spm_rsp_meta_t meta_i,
  output spm_rsp_meta_t meta_o
);

  spm_rsp_meta_t stage_q [Depth];

  // Shift metadata one stage per cycle; clear drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= meta_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign meta_o = stage_q[Depth-1];

endmodule

// File: rtl/spm_bank_ctrl.sv
// rtl/spm_bank_ctrl.sv - row-decoding SRAM bank controller with zero-init
module spm_bank_ctrl
  import spm_pkg::*;
#(
  parameter int DataWidth    = 64,
  parameter int WordsPerBank = 1024,
  parameter int NumBankRows  = 4,
  parameter int AddrWidth    = 18,
  parameter int SramLatency  = 1,
  parameter int InitOnReset  = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  output logic                             init_done_o,
  input  logic                             mem_req_i,
  output logic                             mem_gnt_o,
  input  logic [AddrWidth-1:0]             mem_addr_i,
  input  logic                             mem_we_i,
  input  logic [DataWidth-1:0]             mem_wdata_i,
  input  logic [DataWidth/8-1:0]           mem_strb_i,
  output logic                             mem_rvalid_o,
  output logic [DataWidth-1:0]             mem_rdata_o,
  output logic                             err_o,
  output logic [NumBankRows-1:0]           sram_req_o,
  output logic                             sram_we_o,
  output logic [$clog2(WordsPerBank)-1:0]  sram_addr_o,
  output logic [DataWidth-1:0]             sram_wdata_o,
  output logic [DataWidth/8-1:0]           sram_be_o,
  input  logic [NumBankRows*DataWidth-1:0] sram_rdata_i
);

  localparam int ByteOffW  = $clog2(DataWidth / 8);
  localparam int WordAddrW = $clog2(WordsPerBank);
  localparam int RowSelW   = NumBankRows > 1 ? $clog2(NumBankRows) : 0;
  localparam int HiLsb     = ByteOffW + WordAddrW + RowSelW;
  localparam logic [WordAddrW:0] IcLast = (WordAddrW + 1)'(WordsPerBank - 1);

  spm_ctrl_state_e      state_q;
  logic [WordAddrW:0]   ic_q;
  logic                 in_init;
  logic                 in_run;
  logic [SPM_ROW_W-1:0] row;
  logic                 oor_hi;
  logic                 oor;
  spm_rsp_meta_t        meta_in;
  spm_rsp_meta_t        meta_out;
  logic [DataWidth-1:0] rd_sel;

  assign in_init     = (state_q == SPM_INIT);
  assign in_run      = (state_q == SPM_RUN);
  assign init_done_o = in_run;

  // Init walks every word once, then the block stays in RUN until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (InitOnReset != 0) ? SPM_INIT : SPM_RUN;
      ic_q    <= '0;
    end else if (in_init) begin
      ic_q <= ic_q + 1'b1;
      if (ic_q == IcLast) state_q <= SPM_RUN;
    end
  end

  if (RowSelW > 0) begin : g_row
    assign row = SPM_ROW_W'(mem_addr_i[ByteOffW+WordAddrW +: RowSelW]);
  end else begin : g_no_row
    assign row = '0;
  end

  if (HiLsb < AddrWidth) begin : g_hi
    assign oor_hi = |mem_addr_i[AddrWidth-1:HiLsb];
  end else begin : g_no_hi
    assign oor_hi = 1'b0;
  end

  if (ByteOffW > 0) begin : g_boff
    logic unused_byte_off;
    assign unused_byte_off = ^mem_addr_i[ByteOffW-1:0];
  end

  assign oor       = ({24'd0, row} >= 32'(NumBankRows)) || oor_hi;
  assign mem_gnt_o = in_run && mem_req_i && !rst_i;

  // Shared SRAM bus: zero-fill pattern during init, pass-through in RUN.
  always_comb begin
    sram_we_o    = mem_we_i;
    sram_addr_o  = mem_addr_i[ByteOffW +: WordAddrW];
    sram_wdata_o = mem_wdata_i;
    sram_be_o    = mem_strb_i;
    if (in_init) begin
      sram_we_o    = 1'b1;
      sram_addr_o  = ic_q[WordAddrW-1:0];
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
  end

  // Per-macro request: all rows during init, the decoded row in RUN.
  always_comb begin
    sram_req_o = '0;
    if (!rst_i) begin
      if (in_init) begin
        sram_req_o = '1;
      end else begin
        for (int r = 0; r < NumBankRows; r++) begin
          if (mem_req_i && !oor && row == SPM_ROW_W'(r)) sram_req_o[r] = 1'b1;
        end
      end
    end
  end

  assign meta_in = '{valid: mem_gnt_o, row: row, is_write: mem_we_i, oor: oor};

  spm_rsp_pipe #(.Depth(SramLatency)) u_rsp_pipe (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .meta_i (meta_in),
    .meta_o (meta_out)
  );

  // Pick the read data of the row that was addressed SramLatency cycles ago.
  always_comb begin
    rd_sel = '0;
    for (int r = 0; r < NumBankRows; r++) begin
      if (meta_out.row == SPM_ROW_W'(r)) rd_sel = sram_rdata_i[r*DataWidth +: DataWidth];
    end
  end

  assign mem_rvalid_o = meta_out.valid;
  assign err_o        = meta_out.valid && meta_out.oor;
  assign mem_rdata_o  = (meta_out.valid && !meta_out.is_write && !meta_out.oor) ? rd_sel : '0;

endmodule

// File: tb/tb_spm_bank_ctrl.sv
// tb/tb_spm_bank_ctrl.sv - scoreboard bench for spm_bank_ctrl
module tb_spm_bank_ctrl;

  localparam int DW  = 64;
  localparam int WPB = 16;
  localparam int NR  = 3;
  localparam int AW  = 18;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           init_done, gnt, rvalid, err;
  logic           req, we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata, rdata;
  logic [7:0]     strb;
  logic [NR-1:0]  sram_req;
  logic           sram_we;
  logic [3:0]     sram_addr;
  logic [DW-1:0]  sram_wdata;
  logic [7:0]     sram_be;
  logic [NR*DW-1:0] sram_rdata;

  logic           n_init_done, n_gnt, n_rvalid, n_err, n_req;
  logic [DW-1:0]  n_rdata;
  logic [3:0]     n_sram_req;
  logic           n_sram_we;
  logic [9:0]     n_sram_addr;
  logic [DW-1:0]  n_sram_wdata;
  logic [7:0]     n_sram_be;

  spm_bank_ctrl #(.DataWidth(DW), .WordsPerBank(WPB), .NumBankRows(NR), .AddrWidth(AW),
                  .SramLatency(LAT), .InitOnReset(1)) dut (
    .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
    .mem_req_i(req), .mem_gnt_o(gnt), .mem_addr_i(addr), .mem_we_i(we),
    .mem_wdata_i(wdata), .mem_strb_i(strb), .mem_rvalid_o(rvalid),
    .mem_rdata_o(rdata), .err_o(err), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  spm_bank_ctrl #(.InitOnReset(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .init_done_o(n_init_done),
    .mem_req_i(n_req), .mem_gnt_o(n_gnt), .mem_addr_i(18'h0), .mem_we_i(1'b0),
    .mem_wdata_i(64'h0), .mem_strb_i(8'h0), .mem_rvalid_o(n_rvalid),
    .mem_rdata_o(n_rdata), .err_o(n_err), .sram_req_o(n_sram_req), .sram_we_o(n_sram_we),
    .sram_addr_o(n_sram_addr), .sram_wdata_o(n_sram_wdata), .sram_be_o(n_sram_be),
    .sram_rdata_i(256'h0)
  );

  // SRAM macro model with a two-cycle read latency
  logic [DW-1:0] mem [NR][WPB];
  logic [DW-1:0] rd1 [NR];
  logic [DW-1:0] rd2 [NR];

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (sram_req[r]) begin
        if (sram_we) begin
          for (int b = 0; b < 8; b++) begin
            if (sram_be[b]) mem[r][sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
          end
        end else begin
          rd1[r] <= mem[r][sram_addr];
        end
      end
      rd2[r] <= rd1[r];
    end
  end
  assign sram_rdata = {rd2[2], rd2[1], rd2[0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    int            c;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation
  always @(negedge clk) begin
    if (rvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h err %b with nothing outstanding", rdata, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("response", {rdata, err, cyc}, {e.d, e.e, e.c});
      end
    end else if (err) begin
      errors++;
      checks++;
      $display("FAIL err_without_rvalid: got err 1 expected 0");
    end
  end

  task automatic access(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [7:0] s, input logic [NR-1:0] exp_req,
                        input logic [DW-1:0] exp_d, input logic exp_e, input bit push);
    @(posedge clk); #1;
    req = 1'b1; addr = a; we = w; wdata = d; strb = s;
    @(negedge clk);
    chk("grant", {gnt, sram_req}, {1'b1, exp_req});
    if (push) q.push_back('{d: exp_d, e: exp_e, c: cyc + LAT});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; n_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; strb = 8'hFF; n_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {gnt, rvalid, rdata, err, sram_req, init_done}, '0);
    chk("reset_out_n", {n_gnt, n_rvalid, n_rdata, n_err, n_sram_req}, '0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < WPB; k++) begin
      @(negedge clk);
      chk("init_word", {sram_req, sram_we, sram_addr, sram_be, sram_wdata, init_done, gnt},
          {3'b111, 1'b1, 4'(k), 8'hFF, 64'h0, 1'b0, 1'b0});
      if (k == 0) chk("no_init_run", {n_init_done, n_gnt}, 2'b11);
    end
    @(negedge clk);
    chk("first_grant", {init_done, gnt, sram_req}, {1'b1, 1'b1, 3'b001});
    q.push_back('{d: 64'h0, e: 1'b0, c: cyc + LAT});
    idle();

    access(18'h028, 1'b1, 64'hDEADBEEF_00000001, 8'hFF, 3'b001, 64'h0, 1'b0, 1'b1);
    access(18'h128, 1'b1, 64'h2, 8'hFF, 3'b100, 64'h0, 1'b0, 1'b1);
    access(18'h028, 1'b0, 64'h0, 8'hFF, 3'b001, 64'hDEADBEEF_00000001, 1'b0, 1'b1);
    access(18'h128, 1'b0, 64'h0, 8'hFF, 3'b100, 64'h2, 1'b0, 1'b1);

    access(18'h0B8, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 3'b010, 64'h0, 1'b0, 1'b1);
    access(18'h0B8, 1'b0, 64'h0, 8'hFF, 3'b010, 64'h00000000_FFFFFFFF, 1'b0, 1'b1);

    access(18'h180, 1'b0, 64'h0, 8'hFF, 3'b000, 64'h0, 1'b1, 1'b1);
    access(18'h200, 1'b0, 64'h0, 8'hFF, 3'b000, 64'h0, 1'b1, 1'b1);
    access(18'h20028, 1'b1, 64'h5555, 8'hFF, 3'b000, 64'h0, 1'b1, 1'b1);
    access(18'h028, 1'b0, 64'h0, 8'hFF, 3'b001, 64'hDEADBEEF_00000001, 1'b0, 1'b1);
    idle();
    repeat (4) idle();

    access(18'h028, 1'b0, 64'h0, 8'hFF, 3'b001, 64'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reinit_start", {sram_req, sram_we, sram_addr, init_done, rvalid}, {3'b111, 1'b1, 4'h0, 1'b0, 1'b0});
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done) break;
      n++;
    end
    chk("reinit_len", 32'(n), 32'(WPB));

    access(18'h028, 1'b0, 64'h0, 8'hFF, 3'b001, 64'h0, 1'b0, 1'b1);
    idle();
    repeat (5) idle();
    @(negedge clk);
    chk("drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
